capture_sequencer: RTL and testbench

- Sequences one acquisition cycle of filter_manager: arm, detect a level-crossing trigger on the incoming sample stream, issue the one-cycle trigger pulse, and count CAPTURE_LENGTH samples.
- Then waits for filter completion, hands off to readout, and re-arms after a holdoff (normal mode) or stops (single mode).
- Sits between the ADC sample stream (axiiv/axiid) and filter_manager/readout logic.

---
 rtl/capture_pkg.sv | 15 +
 rtl/edge_trigger_detect.sv | 37 +++
 rtl/capture_sequencer.sv | 131 +++++++++++++
 tb/tb_capture_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and counter-width helper for the capture sequencer.
package capture_pkg;
   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_ARMED       = 3'd1,
      S_CAPTURE     = 3'd2,
      S_FILTER_WAIT = 3'd3,
      S_READOUT     = 3'd4,
      S_HOLDOFF     = 3'd5
   } seq_state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/edge_trigger_detect.sv
// edge_trigger_detect: remembers the previous accepted sample and flags a level crossing on the current beat.
module edge_trigger_detect #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   input  logic         axiiv,
   input  logic [W-1:0] axiid,
   input  logic [W-1:0] trig_level,
   input  logic         trig_rising,
   output logic         crossing
);
   logic [W-1:0] prev_sample_q, prev_sample_d;
   logic         have_prev_q, have_prev_d;
   logic         take;

   always_comb begin
      take          = en && axiiv;
      prev_sample_d = take ? axiid : prev_sample_q;
      have_prev_d   = clr ? 1'b0 : (take ? 1'b1 : have_prev_q);
      crossing      = take && have_prev_q && (trig_rising
                      ? (prev_sample_q <  trig_level && axiid >= trig_level)
                      : (prev_sample_q >= trig_level && axiid <  trig_level));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_sample_q <= '0;
         have_prev_q   <= 1'b0;
      end else begin
         prev_sample_q <= prev_sample_d;
         have_prev_q   <= have_prev_d;
      end
   end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: arm / trigger / capture / filter-wait / readout / holdoff sequencing for one acquisition.
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int SAMPLE_DATA_WIDTH = 8,
   parameter int CAPTURE_LENGTH    = 1000,
   parameter int HOLDOFF_CYCLES    = 1000
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               arm,
   input  logic                               abort,
   input  logic                               single_mode,
   input  logic                               trig_rising,
   input  logic [SAMPLE_DATA_WIDTH-1:0]       trig_level,
   input  logic                               force_trigger,
   input  logic                               axiiv,
   input  logic [SAMPLE_DATA_WIDTH-1:0]       axiid,
   input  logic                               filter_done,
   input  logic                               readout_done,
   output logic                               filter_trigger,
   output logic                               capture_active,
   output logic [$clog2(CAPTURE_LENGTH)-1:0]  sample_index,
   output logic                               readout_start,
   output logic                               overrun,
   output logic [2:0]                         state_o
);
   localparam int IW = $clog2(CAPTURE_LENGTH);
   localparam int HW = cnt_width(HOLDOFF_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(CAPTURE_LENGTH - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

   seq_state_t    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          filter_trigger_q, filter_trigger_d;
   logic          readout_start_q, readout_start_d;
   logic          overrun_q, overrun_d;
   logic          crossing, clr_prev;

   edge_trigger_detect #(.W(SAMPLE_DATA_WIDTH)) u_edge (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (state_q == S_ARMED),
      .clr         (clr_prev),
      .axiiv       (axiiv),
      .axiid       (axiid),
      .trig_level  (trig_level),
      .trig_rising (trig_rising),
      .crossing    (crossing)
   );

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      hold_d           = hold_q;
      filter_trigger_d = 1'b0;
      readout_start_d  = 1'b0;
      overrun_d        = overrun_q;
      clr_prev         = 1'b0;
      case (state_q)
         S_IDLE: if (arm) begin
            state_d   = S_ARMED;
            overrun_d = 1'b0;
            clr_prev  = 1'b1;
         end
         S_ARMED: if (crossing || force_trigger) begin
            state_d          = S_CAPTURE;
            idx_d            = '0;
            filter_trigger_d = 1'b1;
         end
         S_CAPTURE: if (axiiv) begin
            state_d = (idx_q == IDX_LAST) ? S_FILTER_WAIT : S_CAPTURE;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end
         S_FILTER_WAIT: begin
            overrun_d = overrun_q || axiiv;
            if (filter_done) begin
               state_d         = S_READOUT;
               readout_start_d = 1'b1;
            end
         end
         S_READOUT: begin
            overrun_d = overrun_q || axiiv;
            if (readout_done) begin
               state_d = single_mode ? S_IDLE : S_HOLDOFF;
               hold_d  = '0;
            end
         end
         S_HOLDOFF: begin
            state_d  = (hold_q == HOLD_LAST) ? S_ARMED : S_HOLDOFF;
            hold_d   = (hold_q == HOLD_LAST) ? '0 : hold_q + 1'b1;
            clr_prev = (hold_q == HOLD_LAST);
         end
         default: state_d = S_IDLE;
      endcase
      // abort overrides every transition and swallows any pulse due this cycle
      if (abort) begin
         state_d          = S_IDLE;
         idx_d            = '0;
         hold_d           = '0;
         filter_trigger_d = 1'b0;
         readout_start_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         hold_q           <= '0;
         filter_trigger_q <= 1'b0;
         readout_start_q  <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         hold_q           <= hold_d;
         filter_trigger_q <= filter_trigger_d;
         readout_start_q  <= readout_start_d;
         overrun_q        <= overrun_d;
      end
   end

   assign filter_trigger = filter_trigger_q;
   assign readout_start  = readout_start_q;
   assign overrun        = overrun_q;
   assign sample_index   = idx_q;
   assign capture_active = (state_q == S_CAPTURE);
   assign state_o        = state_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: scenario tasks with randomized samples checked against a crossing-scan model.
module tb_capture_sequencer;
   localparam int L = 1000;
   localparam int H = 1000;

   logic       clk = 0, rst_n = 0, arm = 0, abort = 0, single_mode = 0, trig_rising = 1;
   logic       force_trigger = 0, axiiv = 0, filter_done = 0, readout_done = 0;
   logic [7:0] trig_level = 0, axiid = 0;
   logic       filter_trigger, capture_active, readout_start, overrun;
   logic [9:0] sample_index;
   logic [2:0] state_o;
   int         n_chk = 0, n_fail = 0;

   capture_sequencer #(.SAMPLE_DATA_WIDTH(8), .CAPTURE_LENGTH(L), .HOLDOFF_CYCLES(H)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .single_mode(single_mode),
      .trig_rising(trig_rising), .trig_level(trig_level), .force_trigger(force_trigger),
      .axiiv(axiiv), .axiid(axiid), .filter_done(filter_done), .readout_done(readout_done),
      .filter_trigger(filter_trigger), .capture_active(capture_active), .sample_index(sample_index),
      .readout_start(readout_start), .overrun(overrun), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic bit crosses(input int p, input int c, input int lvl, input bit rising);
      return rising ? (p < lvl && c >= lvl) : (p >= lvl && c < lvl);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] v);
      axiid = v;
      axiiv = 1;
      tick();
      axiiv = 0;
   endtask

   task automatic pulse_arm();
      arm = 1; tick(); arm = 0;
   endtask

   task automatic pulse_abort();
      abort = 1; tick(); abort = 0;
   endtask

   task automatic pulse_filter_done();
      filter_done = 1; tick(); filter_done = 0;
   endtask

   task automatic pulse_readout_done();
      readout_done = 1; tick(); readout_done = 0;
   endtask

   task automatic fill_capture();
      force_trigger = 1; tick(); force_trigger = 0;
      for (int i = 0; i < L; i++) beat(8'($urandom));
   endtask

   task automatic test_reset();
      rst_n = 0;
      #2;
      n_chk++;
      if ({filter_trigger, capture_active, sample_index, readout_start, overrun, state_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got ft=%b ca=%b idx=%0d rs=%b ov=%b st=%0d want all 0",
                  filter_trigger, capture_active, sample_index, readout_start, overrun, state_o);
      end
      @(negedge clk) rst_n = 1;
      tick();
   endtask

   task automatic test_rising_directed();
      int seq[5] = '{99, 90, 95, 99, 100};
      trig_rising = 1; trig_level = 100;
      pulse_arm();
      n_chk++;
      if (state_o !== 3'd1) begin n_fail++; $display("FAIL arm_state: got %0d want 1", state_o); end
      for (int i = 0; i < 5; i++) begin
         beat(8'(seq[i]));
         n_chk++;
         if (filter_trigger !== (i == 4)) begin
            n_fail++; $display("FAIL rise_trig beat%0d val %0d: got %b want %b", i, seq[i], filter_trigger, i == 4);
         end
      end
      n_chk++;
      if (state_o !== 3'd2 || capture_active !== 1'b1) begin
         n_fail++; $display("FAIL capture_entry: got st=%0d ca=%b want 2/1", state_o, capture_active);
      end
      for (int k = 0; k < L; k++) begin
         if (k > 0) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            n_chk++;
            if (filter_trigger !== 1'b0) begin n_fail++; $display("FAIL trig_width at idx %0d: got 1 want 0", k); end
         end
         n_chk++;
         if (sample_index !== 10'(k) || capture_active !== 1'b1) begin
            n_fail++; $display("FAIL sample_index: got %0d ca=%b want %0d ca=1", sample_index, capture_active, k);
         end
         beat(k == 0 ? 8'd101 : 8'($urandom));
      end
      n_chk++;
      if (state_o !== 3'd3 || sample_index !== 10'd0 || capture_active !== 1'b0) begin
         n_fail++; $display("FAIL capture_end: got st=%0d idx=%0d ca=%b want 3/0/0", state_o, sample_index, capture_active);
      end
      pulse_abort();
   endtask

   task automatic test_rising_random();
      for (int r = 0; r < 16; r++) begin
         int s[10];
         int lvl, first;
         bit rising;
         lvl = int'($urandom_range(0, 255));
         rising = 1'($urandom);
         first = -1;
         for (int i = 0; i < 10; i++) begin
            s[i] = lvl + int'($urandom_range(0, 40)) - 20;
            s[i] = s[i] < 0 ? 0 : (s[i] > 255 ? 255 : s[i]);
         end
         for (int i = 1; i < 10; i++)
            if (first < 0 && crosses(s[i-1], s[i], lvl, rising)) first = i;
         trig_level = 8'(lvl); trig_rising = rising;
         pulse_arm();
         for (int i = 0; i < 10 && (first < 0 || i <= first); i++) begin
            if ($urandom_range(0, 1) == 1) tick();
            beat(8'(s[i]));
            n_chk++;
            if (filter_trigger !== (i == first)) begin
               n_fail++; $display("FAIL rand_trig r%0d beat%0d: got %b want %b", r, i, filter_trigger, i == first);
            end
         end
         if (first < 0) begin
            force_trigger = 1; tick(); force_trigger = 0;
            n_chk++;
            if (filter_trigger !== 1'b1) begin n_fail++; $display("FAIL force_trig r%0d: got 0 want 1", r); end
         end
         n_chk++;
         if (state_o !== 3'd2) begin n_fail++; $display("FAIL rand_capture r%0d: got %0d want 2", r, state_o); end
         pulse_abort();
      end
   endtask

   task automatic test_falling();
      int seq[4] = '{200, 130, 128, 127};
      trig_rising = 0; trig_level = 128;
      pulse_arm();
      for (int i = 0; i < 4; i++) begin
         beat(8'(seq[i]));
         n_chk++;
         if (filter_trigger !== (i == 3)) begin
            n_fail++; $display("FAIL fall_trig val %0d: got %b want %b", seq[i], filter_trigger, i == 3);
         end
      end
      pulse_abort();
      pulse_arm();
      beat(8'd200);
      force_trigger = 1;
      beat(8'd100);
      force_trigger = 0;
      n_chk++;
      if (filter_trigger !== 1'b1) begin n_fail++; $display("FAIL force_and_cross: got 0 want 1"); end
      tick();
      n_chk++;
      if (filter_trigger !== 1'b0 || state_o !== 3'd2) begin
         n_fail++; $display("FAIL single_pulse: got ft=%b st=%0d want 0/2", filter_trigger, state_o);
      end
      pulse_abort();
   endtask

   task automatic test_handshake();
      int cnt;
      single_mode = 0;
      pulse_arm();
      fill_capture();
      repeat (3) tick();
      n_chk++;
      if (state_o !== 3'd3) begin n_fail++; $display("FAIL filter_wait: got %0d want 3", state_o); end
      pulse_filter_done();
      n_chk++;
      if (readout_start !== 1'b1 || state_o !== 3'd4) begin
         n_fail++; $display("FAIL readout_start: got rs=%b st=%0d want 1/4", readout_start, state_o);
      end
      tick();
      n_chk++;
      if (readout_start !== 1'b0) begin n_fail++; $display("FAIL readout_width: got 1 want 0"); end
      pulse_readout_done();
      cnt = 0;
      while (state_o === 3'd5 && cnt < 3 * H) begin cnt++; tick(); end
      n_chk++;
      if (cnt != H || state_o !== 3'd1) begin
         n_fail++; $display("FAIL holdoff: got %0d cycles then st=%0d want %0d then 1", cnt, state_o, H);
      end
      fill_capture();
      pulse_filter_done();
      tick();
      single_mode = 1;
      pulse_readout_done();
      single_mode = 0;
      n_chk++;
      if (state_o !== 3'd0) begin n_fail++; $display("FAIL single_stop: got %0d want 0", state_o); end
   endtask

   task automatic test_overrun();
      single_mode = 0;
      pulse_arm();
      fill_capture();
      n_chk++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear_start: got 1 want 0"); end
      beat(8'd5);
      n_chk++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got 0 want 1"); end
      pulse_filter_done();
      pulse_readout_done();
      n_chk++;
      if (overrun !== 1'b1 || state_o !== 3'd5) begin
         n_fail++; $display("FAIL overrun_hold: got ov=%b st=%0d want 1/5", overrun, state_o);
      end
      pulse_abort();
      n_chk++;
      if (overrun !== 1'b1 || state_o !== 3'd0) begin
         n_fail++; $display("FAIL overrun_abort: got ov=%b st=%0d want 1/0", overrun, state_o);
      end
      pulse_arm();
      n_chk++;
      if (overrun !== 1'b0 || state_o !== 3'd1) begin
         n_fail++; $display("FAIL overrun_arm: got ov=%b st=%0d want 0/1", overrun, state_o);
      end
      pulse_arm();
      n_chk++;
      if (state_o !== 3'd1) begin n_fail++; $display("FAIL arm_ignored: got %0d want 1", state_o); end
      pulse_abort();
   endtask

   task automatic test_abort();
      for (int t = 0; t < 4; t++) begin
         single_mode = 0;
         pulse_arm();
         if (t == 1) begin
            force_trigger = 1; tick(); force_trigger = 0;
            repeat (3) beat(8'($urandom));
            n_chk++;
            if (sample_index !== 10'd3) begin n_fail++; $display("FAIL pre_abort_idx: got %0d want 3", sample_index); end
         end
         if (t >= 2) fill_capture();
         if (t == 3) begin
            pulse_filter_done();
            pulse_readout_done();
            repeat (10) tick();
         end
         force_trigger = (t == 0);
         filter_done = (t == 2);
         axiiv = (t == 1);
         pulse_abort();
         force_trigger = 0; filter_done = 0; axiiv = 0;
         n_chk++;
         if ({state_o, sample_index, filter_trigger, readout_start} !== '0) begin
            n_fail++; $display("FAIL abort_case%0d: got st=%0d idx=%0d ft=%b rs=%b want all 0",
                               t, state_o, sample_index, filter_trigger, readout_start);
         end
      end
   endtask

   task automatic test_reset_mid_capture();
      trig_rising = 1; trig_level = 100;
      pulse_arm();
      force_trigger = 1; tick(); force_trigger = 0;
      repeat (500) beat(8'($urandom));
      n_chk++;
      if (sample_index !== 10'd500) begin n_fail++; $display("FAIL mid_idx: got %0d want 500", sample_index); end
      #2 rst_n = 0;
      #1;
      n_chk++;
      if ({filter_trigger, capture_active, sample_index, readout_start, overrun, state_o} !== '0) begin
         n_fail++; $display("FAIL async_reset: got ft=%b ca=%b idx=%0d rs=%b ov=%b st=%0d want all 0",
                            filter_trigger, capture_active, sample_index, readout_start, overrun, state_o);
      end
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         beat(i % 2 ? 8'd150 : 8'd50);
         n_chk++;
         if (filter_trigger !== 1'b0 || state_o !== 3'd0) begin
            n_fail++; $display("FAIL post_reset cyc%0d: got ft=%b st=%0d want 0/0", i, filter_trigger, state_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rising_directed();
      test_rising_random();
      test_falling();
      test_handshake();
      test_overrun();
      test_abort();
      test_reset_mid_capture();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
